booth_operand_feeder: RTL and testbench

Upstream issue stage for the 4-bit radix-2 Booth multiplier. Buffers signed operand pairs from a producer via valid/ready, issues them one at a time to the multiplier (`start` pulse with X/Y held stable for the whole operation), and captures each 8-bit product into an output register with its own valid/ready handshake. Exactly one multiplication is in flight at a time; results leave in issue order.

---
 rtl/booth_pkg.sv | 7 +
 rtl/booth_op_fifo.sv | 37 +++
 rtl/booth_operand_feeder.sv | 76 +++++++
 tb/tb_booth_operand_feeder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM state, widths and timing constants for the Booth operand feeder.
package booth_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  localparam int OPW_DEFAULT = 4;
  localparam int BOOTH_LATENCY = 5;
  localparam int WD_LIMIT = 15;
endpackage

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: circular operand FIFO with wrap-around pointers and an occupancy count.
module booth_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW + 1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (do_push && !do_pop) ? count + 1'b1 : (do_pop && !do_push) ? count - 1'b1 : count;
    end
endmodule

// File: rtl/booth_operand_feeder.sv
// booth_operand_feeder: queues signed operand pairs and issues them one at a time to the Booth multiplier.
// Optional watchdog with err output when BOOTH_FEEDER_TIMEOUT_EN is defined.
module booth_operand_feeder
  import booth_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW = OPW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_x,
  input  logic [OPW-1:0]   in_y,
  output logic             mul_start,
  output logic [OPW-1:0]   mul_x,
  output logic [OPW-1:0]   mul_y,
  input  logic             mul_valid,
  input  logic [2*OPW-1:0] mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] out_z,
  output logic             busy
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  ,output logic            err
`endif
);
  state_t state, state_nx;
  logic [2*OPW-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, pop, capture, timeout;
  booth_op_fifo #(.DEPTH(DEPTH), .W(2*OPW)) u_fifo (
    .clk, .rst, .push(in_valid && in_ready), .pop, .din({in_x, in_y}),
    .dout(head), .full, .empty, .count
  );
  assign in_ready = !full;
  // issue only when the result slot is guaranteed free by the time the product lands
  assign pop = state == IDLE && !empty && (!out_valid || out_ready);
  assign capture = state == BUSY && mul_valid;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  logic [3:0] wd;
  assign timeout = state == BUSY && !mul_valid && wd == 4'(WD_LIMIT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd <= '0;
      err <= 1'b0;
    end else begin
      wd <= state == BUSY ? wd + 1'b1 : '0;
      err <= timeout;
    end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && pop) ? ISSUE :
               state == ISSUE ? BUSY :
               (state == BUSY && (capture || timeout)) ? IDLE : state;
  always_comb begin
    mul_start = state == ISSUE;
    busy = state != IDLE || count != '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mul_x <= '0;
      mul_y <= '0;
      out_valid <= 1'b0;
      out_z <= '0;
    end else begin
      if (pop) {mul_x, mul_y} <= head;
      if (capture) out_z <= mul_z;
      out_valid <= capture || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_booth_operand_feeder.sv
// tb_booth_operand_feeder: directed checks of the operand feeder against a 5-cycle Booth multiplier model.
module tb_booth_operand_feeder;
  import booth_pkg::*;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready;
  logic [3:0] in_x = 0, in_y = 0;
  logic mul_start, mul_valid = 0;
  logic [3:0] mul_x, mul_y;
  logic [7:0] mul_z = 0, out_z;
  logic out_valid, out_ready = 1, busy;
`ifdef BOOTH_FEEDER_TIMEOUT_EN
  logic err;
`endif
  int errors = 0, checks = 0;
  logic model_en = 1, spur = 0;
  logic [7:0] spur_z = 0, prod = 0;
  int cnt = 0;

  booth_operand_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y), .mul_valid(mul_valid), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
`ifdef BOOTH_FEEDER_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // multiplier model: product presented BOOTH_LATENCY cycles after the start cycle
  initial forever begin
    @(negedge clk);
    #1;
    mul_valid = spur;
    if (spur) mul_z = spur_z;
    if (!rst) cnt = 0;
    else if (model_en && mul_start) begin
      cnt = BOOTH_LATENCY;
      prod = 8'($signed({{4{mul_x[3]}}, mul_x}) * $signed({{4{mul_y[3]}}, mul_y}));
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mul_valid = 1;
        mul_z = prod;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] x, input logic [3:0] y);
    in_valid = 1;
    in_x = x;
    in_y = y;
    step();
    in_valid = 0;
  endtask

  task automatic wait_result(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check(tag, {out_valid, out_z}, {1'b1, exp});
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  initial begin
    logic seen;
    logic [3:0] fx [5] = '{4'h8, 4'h7, 4'h8, 4'h0, 4'hF};
    logic [3:0] fy [5] = '{4'h8, 4'h7, 4'h7, 4'h5, 4'hF};
    logic [7:0] fz [5] = '{8'h40, 8'h31, 8'hC8, 8'h00, 8'h01};
    repeat (2) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_xy", {mul_x, mul_y}, 0);
    check("rst_out", {out_valid, out_z}, 0);
    check("rst_busy", busy, 0);
    rst = 1;
    repeat (2) step();

    // single op 3 x -2, cycle P is this negedge
    push(4'h3, 4'hE);
    check("s_p1_start", {mul_start, busy}, 2'b01);
    step();
    check("s_p2_start", mul_start, 1);
    check("s_p2_xy", {mul_x, mul_y}, 8'h3E);
    for (int i = 3; i <= 7; i++) begin
      step();
      check("s_busy_hold", {mul_start, out_valid, mul_x, mul_y}, {2'b00, 8'h3E});
    end
    step();
    check("s_p8_out", {out_valid, out_z}, {1'b1, 8'hFA});
    step();
    check("s_drained", {out_valid, busy}, 0);

    // fill with results held back
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      check("f_ready", in_ready, 1);
      push(fx[i], fy[i]);
    end
    check("f_full", in_ready, 0);
    in_valid = 1;
    in_x = 4'h2;
    in_y = 4'h3;
    repeat (4) step();
    check("f_refused", in_ready, 0);
    in_valid = 0;
    for (int i = 0; i < 5; i++) wait_result("f_result", fz[i]);
    repeat (20) step();
    check("f_no_extra", {out_valid, busy, in_ready}, 3'b001);

    // backpressure: first result held, second op waits
    push(4'h2, 4'h3);
    push(4'hD, 4'h5);
    for (int n = 0; n < 40 && !out_valid; n++) step();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mul_start) seen = 1;
    end
    check("b_no_start", seen, 0);
    check("b_held", {out_valid, out_z}, {1'b1, 8'h06});
    out_ready = 1;
    step();
    out_ready = 0;
    check("b_start_after", {mul_start, out_valid}, 2'b10);
    wait_result("b_second", 8'hF1);

    // spurious mul_valid in IDLE, then in ISSUE
    out_ready = 1;
    spur_z = 8'h77;
    spur = 1;
    step();
    spur = 0;
    step();
    check("sp_idle", out_valid, 0);
    push(4'h1, 4'h1);
    step();
    check("sp_in_issue", mul_start, 1);
    spur = 1;
    step();
    spur = 0;
    step();
    check("sp_issue", out_valid, 0);
    out_ready = 0;
    wait_result("sp_result", 8'h01);

    // reset during BUSY
    out_ready = 1;
    push(4'h9, 4'h3);
    repeat (3) step();
    rst = 0;
    #1;
    check("r_ctrl", {in_ready, mul_start, out_valid, busy}, 4'b1000);
    check("r_mul_xy", {mul_x, mul_y}, 0);
    check("r_out_z", out_z, 0);
    step();
    rst = 1;
    repeat (10) step();
    check("r_discarded", {out_valid, out_z}, 0);
    push(4'hB, 4'h3);
    repeat (6) step();
    check("r_p7", out_valid, 0);
    step();
    check("r_p8", {out_valid, out_z}, {1'b1, 8'hF1});

`ifdef BOOTH_FEEDER_TIMEOUT_EN
    step();
    model_en = 0;
    push(4'h2, 4'h2);
    push(4'h3, 4'h3);
    check("t_start", mul_start, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (err) seen = 1;
    end
    check("t_early_err", seen, 0);
    step();
    model_en = 1;
    check("t_err", {err, out_valid}, 2'b10);
    out_ready = 0;
    wait_result("t_next", 8'h09);
    check("t_err_clear", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
